md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide responder for the pipelined MIPS core.
- The E-stage issues a start pulse; md_unit owns HI/LO, computes the result, holds busy for a fixed latency, then commits HI/LO.
- The hazard unit stalls mult/div/mfhi/mflo/mthi/mtlo while busy or start is high.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high after a MULT/MULTU start (>=1).
- DIV_CYCLES, 10, cycles busy stays high after a DIV/DIVU start (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; op, a and b are valid in the same cycle.
- op  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved.
- a  input  32  rs operand.
- b  input  32  rt operand.
- busy  output  1  operation in flight, registered.
- hi  output  32  architectural HI, registered.
- lo  output  32  architectural LO, registered.

Behaviour:
- Reset (async, any time, including mid-operation):
  - busy=0, hi=0, lo=0, counter=0, pending result discarded.
- States: IDLE, RUN.
- IDLE, start with op MULT/MULTU/DIV/DIVU at edge t:
  - Full result is computed combinationally from a, b and latched into hi_next/lo_next.
  - counter loads N-1, where N = MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from edge t through edge t+N.
- RUN: counter decrements each cycle. At the edge where counter==0:
  - hi<=hi_next, lo<=lo_next, busy<=0, go to IDLE.
  - The new hi/lo are therefore visible in the same cycle busy first reads 0.
- Latency: hi/lo valid N cycles after the start edge. Throughput is one operation per N+1 cycles.
- MTHI/MTLO with start in IDLE:
  - hi<=a (or lo<=a) at the next edge; busy stays 0; single cycle.
- start asserted during RUN:
  - Ignored for every op; the hazard unit guarantees this never occurs.
  - Verification flags it with an assertion, not as a functional case.
- Reserved op with start: no effect, no busy.
- Arithmetic:
  - MULT: signed 32x32->64; hi = [63:32], lo = [31:0]. MULTU: unsigned.
  - DIV: signed, lo = quotient truncated toward zero, hi = remainder with the sign of the dividend. DIVU: unsigned.
- Divide by zero (b==0):
  - DIV/DIVU: lo=32'hFFFF_FFFF, hi=a; full DIV_CYCLES latency still applies.
- Signed overflow (DIV with a=32'h8000_0000, b=32'hFFFF_FFFF): lo=32'h8000_0000, hi=0.
- Operands are sampled only at the start edge; later changes to a/b have no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Op 6 = MADD and op 7 = MADDU: {hi,lo} <= {hi,lo} + a*b (signed/unsigned 64-bit, wrap on overflow).
  - These take MULT_CYCLES latency.
  - The {hi,lo} accumulator value is captured at the start edge.
- Undefined: ops 6/7 are reserved (no effect), and the logic is absent.

Decomposition:
- Shared package mips_pkg:
  - Op encodings MD_MULT..MD_MADDU as 3-bit localparams.
  - Default latencies.
  - Divide-by-zero fill constant 32'hFFFF_FFFF.
- No sub-module needed. The arithmetic is inline and only the counter/FSM is sequential; a separate module would add only ports.

Test Plan:
- Reset mid-RUN:
  - Start MULT a=3 b=4, assert reset at cycle 2 -> busy=0, hi=0, lo=0 immediately (asynchronous).
  - No commit afterwards.
- Signed multiply:
  - MULT a=32'hFFFF_FFFE (-2), b=3 -> busy high 5 cycles.
  - Then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
  - hi/lo hold their old values throughout busy.
- Signed and unsigned divide:
  - DIV a=-7, b=2 -> after 10 cycles lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
  - DIVU a=7, b=2 -> lo=3, hi=1.
- Divide corner cases:
  - DIVU a=5, b=0 -> lo=32'hFFFF_FFFF, hi=5.
  - DIV a=32'h8000_0000, b=-1 -> lo=32'h8000_0000, hi=0.
- MTHI/MTLO plus ignored start:
  - MTHI a=32'h1234_5678 -> hi updates next edge, busy never rises.
  - Start MULT, then assert start MTLO during RUN -> lo ends equal to the MULT result, not the MTLO operand.
- MDU_MADD_EN:
  - Set hi=0, lo=32'hFFFF_FFFF, then MADDU a=1, b=1 -> hi=1, lo=0 after 5 cycles.
  - Without the macro, op 6 leaves hi/lo unchanged and busy=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: multiply/divide op encodings, default latencies
// and the divide-by-zero fill value.
package mips_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_MADD  = 3'd6;
    localparam logic [2:0] MD_MADDU = 3'd7;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    localparam logic [31:0] MD_DIV0_FILL = 32'hFFFF_FFFF;

    typedef enum logic {
        MD_IDLE,
        MD_RUN
    } md_state_t;

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO: result computed at start, committed after a
// fixed latency. Optional MADD/MADDU accumulate ops are enabled by MDU_MADD_EN.
module md_unit
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    md_state_t     state, state_next;
    logic [CW-1:0] counter, counter_next;
    logic [31:0]   hi_next, lo_next;
    logic [31:0]   res_hi, res_lo;
    logic          op_long;
    logic [CW-1:0] op_load;
    logic          launch, commit;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, abs_b_safe, div_b_safe;
    logic [31:0] mag_q, mag_r, sq, sr, uq, ur;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide works on magnitudes, then restores signs; the safe divisors
    // keep the dividers defined when b is zero (that result is overridden).
    assign abs_a      = a[31] ? (~a + 32'd1) : a;
    assign abs_b      = b[31] ? (~b + 32'd1) : b;
    assign abs_b_safe = (b == 32'd0) ? 32'd1 : abs_b;
    assign div_b_safe = (b == 32'd0) ? 32'd1 : b;
    assign mag_q      = abs_a / abs_b_safe;
    assign mag_r      = abs_a % abs_b_safe;
    assign sq         = (a[31] ^ b[31]) ? (~mag_q + 32'd1) : mag_q;
    assign sr         = a[31] ? (~mag_r + 32'd1) : mag_r;
    assign uq         = a / div_b_safe;
    assign ur         = a % div_b_safe;

    always_comb begin
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        op_long = 1'b0;
        op_load = MULT_LOAD;
        case (op)
            MD_MULT: begin
                {res_hi, res_lo} = prod_s;
                op_long          = 1'b1;
            end
            MD_MULTU: begin
                {res_hi, res_lo} = prod_u;
                op_long          = 1'b1;
            end
            MD_DIV: begin
                res_hi  = (b == 32'd0) ? a : sr;
                res_lo  = (b == 32'd0) ? MD_DIV0_FILL : sq;
                op_long = 1'b1;
                op_load = DIV_LOAD;
            end
            MD_DIVU: begin
                res_hi  = (b == 32'd0) ? a : ur;
                res_lo  = (b == 32'd0) ? MD_DIV0_FILL : uq;
                op_long = 1'b1;
                op_load = DIV_LOAD;
            end
`ifdef MDU_MADD_EN
            MD_MADD: begin
                {res_hi, res_lo} = {hi, lo} + prod_s;
                op_long          = 1'b1;
            end
            MD_MADDU: begin
                {res_hi, res_lo} = {hi, lo} + prod_u;
                op_long          = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Starts arriving while RUN are dropped; the hazard unit never issues them.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        launch       = 1'b0;
        commit       = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start && op_long) begin
                    state_next   = MD_RUN;
                    counter_next = op_load;
                    launch       = 1'b1;
                end
            end
            MD_RUN: begin
                if (counter == '0) begin
                    state_next = MD_IDLE;
                    commit     = 1'b1;
                end else begin
                    counter_next = counter - 1'b1;
                end
            end
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MD_IDLE;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            hi_next <= 32'd0;
            lo_next <= 32'd0;
        end else begin
            if (launch) begin
                hi_next <= res_hi;
                lo_next <= res_lo;
            end
            if (commit) begin
                hi <= hi_next;
                lo <= lo_next;
            end else if (state == MD_IDLE && start && op == MD_MTHI) begin
                hi <= a;
            end else if (state == MD_IDLE && start && op == MD_MTLO) begin
                lo <= a;
            end
        end
    end

    assign busy = (state == MD_RUN);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus random ops checked
// against a plain-arithmetic HI/LO model. Honours MDU_MADD_EN like the design.
module tb_md_unit;
    import mips_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_compared;
    int n_mismatched;
    logic [31:0] mhi;
    logic [31:0] mlo;

    md_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives a one-cycle start pulse, then scrambles operands so late changes are visible.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Reference behaviour straight from the architectural definition of each op.
    function automatic void modelOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] chi, input logic [31:0] clo,
                                    output bit is_long, output int n,
                                    output logic [31:0] ehi, output logic [31:0] elo);
        longint sx;
        longint sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ehi = chi;
        elo = clo;
        is_long = 1'b0;
        n = 0;
        case (o)
            3'd0: begin p = 64'(sx * sy); {ehi, elo} = p; is_long = 1'b1; n = MULT_N; end
            3'd1: begin p = {32'd0, x} * {32'd0, y}; {ehi, elo} = p; is_long = 1'b1; n = MULT_N; end
            3'd2: begin
                is_long = 1'b1; n = DIV_N;
                if (y == 32'd0) begin ehi = x; elo = 32'hFFFF_FFFF; end
                else begin ehi = 32'(sx % sy); elo = 32'(sx / sy); end
            end
            3'd3: begin
                is_long = 1'b1; n = DIV_N;
                if (y == 32'd0) begin ehi = x; elo = 32'hFFFF_FFFF; end
                else begin ehi = x % y; elo = x / y; end
            end
            3'd4: ehi = x;
            3'd5: elo = x;
`ifdef MDU_MADD_EN
            3'd6: begin p = {chi, clo} + 64'(sx * sy); {ehi, elo} = p; is_long = 1'b1; n = MULT_N; end
            3'd7: begin p = {chi, clo} + {32'd0, x} * {32'd0, y}; {ehi, elo} = p; is_long = 1'b1; n = MULT_N; end
`endif
            default: ;
        endcase
    endfunction

    task automatic runOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bit is_long;
        int n;
        logic [31:0] ehi;
        logic [31:0] elo;
        modelOp(o, x, y, mhi, mlo, is_long, n, ehi, elo);
        applyStimulus(o, x, y);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            checkOutput("busy_run", {31'd0, busy}, 32'd1);
            checkOutput("hi_hold", hi, mhi);
            checkOutput("lo_hold", lo, mlo);
        end
        @(negedge clk);
        checkOutput("busy_done", {31'd0, busy}, 32'd0);
        checkOutput("hi_result", hi, ehi);
        checkOutput("lo_result", lo, elo);
        mhi = ehi;
        mlo = elo;
    endtask

    initial begin
        bit is_long;
        int n;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        n_compared   = 0;
        n_mismatched = 0;
        mhi   = 32'd0;
        mlo   = 32'd0;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;

        @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] reset during RUN");
        applyStimulus(MD_MULT, 32'd3, 32'd4);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midrun_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrun_reset_hi", hi, 32'd0);
        checkOutput("midrun_reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (MULT_N + 2) @(negedge clk);
        checkOutput("no_commit_busy", {31'd0, busy}, 32'd0);
        checkOutput("no_commit_hi", hi, 32'd0);
        checkOutput("no_commit_lo", lo, 32'd0);

        $display("[TB] directed arithmetic");
        runOp(MD_MTHI, 32'h0BAD_F00D, 32'd0);
        runOp(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        checkOutput("mult_neg_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_neg_lo", lo, 32'hFFFF_FFFA);
        runOp(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div_neg_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_neg_hi", hi, 32'hFFFF_FFFF);
        runOp(MD_DIVU, 32'd7, 32'd2);
        checkOutput("divu_lo", lo, 32'd3);
        checkOutput("divu_hi", hi, 32'd1);
        runOp(MD_DIVU, 32'd5, 32'd0);
        checkOutput("divu_zero_lo", lo, 32'hFFFF_FFFF);
        checkOutput("divu_zero_hi", hi, 32'd5);
        runOp(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div_ovf_lo", lo, 32'h8000_0000);
        checkOutput("div_ovf_hi", hi, 32'd0);
        runOp(MD_MTHI, 32'h1234_5678, 32'd0);
        checkOutput("mthi_hi", hi, 32'h1234_5678);

        $display("[TB] start ignored while busy");
        modelOp(MD_MULT, 32'h0001_0003, 32'h0000_0007, mhi, mlo, is_long, n, ehi, elo);
        applyStimulus(MD_MULT, 32'h0001_0003, 32'h0000_0007);
        applyStimulus(MD_MTLO, 32'hDEAD_BEEF, 32'd0);
        repeat (MULT_N - 1) begin
            @(negedge clk);
            checkOutput("ignored_busy", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        checkOutput("ignored_done", {31'd0, busy}, 32'd0);
        checkOutput("ignored_lo", lo, elo);
        checkOutput("ignored_hi", hi, ehi);
        checkOutput("ignored_lo_const", lo, 32'h0007_0015);
        mhi = ehi;
        mlo = elo;

`ifdef MDU_MADD_EN
        $display("[TB] MADDU accumulate");
        runOp(MD_MTHI, 32'd0, 32'd0);
        runOp(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
        runOp(MD_MADDU, 32'd1, 32'd1);
        checkOutput("maddu_hi", hi, 32'd1);
        checkOutput("maddu_lo", lo, 32'd0);
`else
        $display("[TB] op 6 reserved");
        runOp(3'd6, 32'd9, 32'd9);
        checkOutput("op6_hi", hi, 32'h0000_0000);
        checkOutput("op6_lo", lo, 32'h0007_0015);
`endif

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            runOp(ro, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
